// File: rtl/digest_reader_pkg.sv
// Shared types and constants for the digest readout path: FSM state encoding
// and the word/byte geometry of the output data memory.
package digest_reader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      SEND,
      DONE
   } state_t;

   localparam int WORD_WIDTH            = 32;
   localparam int BYTES_PER_WORD        = 4;
   localparam int DEFAULT_OUTPUT_LENGTH = 8;
   localparam int DIGEST_BYTES          = BYTES_PER_WORD * DEFAULT_OUTPUT_LENGTH;

endpackage

// File: rtl/digest_reader_word_serializer.sv
// Holds one 32-bit digest word and hands it out MSB-first, one symbol per
// accepted valid/ready beat, flagging the final symbol of the digest.
module digest_reader_word_serializer
   import digest_reader_pkg::*;
#(
   parameter int SYMBOL_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [WORD_WIDTH-1:0]   load_data,
   input  logic                    last_word,
   input  logic                    ready,
   output logic [SYMBOL_WIDTH-1:0] data,
   output logic                    valid,
   output logic                    last,
   output logic                    word_done
);

   localparam int CNT_WIDTH = $clog2(BYTES_PER_WORD);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BYTES_PER_WORD - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_PREV = CNT_WIDTH'(BYTES_PER_WORD - 2);

   logic [WORD_WIDTH-1:0] shift_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  accept;

   // A beat transfers when valid && ready; ready alone has no effect.
   assign accept    = valid && ready;
   assign word_done = accept && (cnt_q == CNT_LAST);
   assign data      = shift_q[WORD_WIDTH-1 -: SYMBOL_WIDTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
         valid   <= 1'b0;
         last    <= 1'b0;
      end else if (load) begin
         shift_q <= load_data;
         cnt_q   <= '0;
         valid   <= 1'b1;
         last    <= 1'b0;
      end else if (accept) begin
         shift_q <= shift_q << SYMBOL_WIDTH;
         cnt_q   <= cnt_q + 1'b1;
         // last rises as the final symbol of the final word comes up
         last    <= last_word && (cnt_q == CNT_PREV);
         if (cnt_q == CNT_LAST) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/digest_reader.sv
// Reads the finished digest out of the output data memory after the hash core
// signals finish, and streams it as bytes over a valid/ready interface.
module digest_reader
   import digest_reader_pkg::*;
#(
   parameter  int OUTPUT_LENGTH = 8,
   parameter  int SYMBOL_WIDTH  = 8,
   localparam int ADDR_WIDTH    = (OUTPUT_LENGTH > 1) ? $clog2(OUTPUT_LENGTH) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    dut__xxx__finish,
   output logic [ADDR_WIDTH-1:0]   rdr__dom__address,
   output logic                    rdr__dom__enable,
   output logic                    rdr__dom__write,
   input  logic [WORD_WIDTH-1:0]   dom__rdr__data,
   output logic [SYMBOL_WIDTH-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    busy,
   output logic                    done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(OUTPUT_LENGTH - 1);

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] word_idx, word_idx_nx;
   logic                  word_done;

   assign rdr__dom__write = 1'b0;

   always_comb begin
      state_nx    = state;
      word_idx_nx = word_idx;
      case (state)
         IDLE: begin
            if (dut__xxx__finish) begin
               state_nx    = REQ;
               word_idx_nx = '0;
            end
         end
         REQ:  state_nx = WAIT;
         WAIT: state_nx = SEND;
         SEND: begin
            if (word_done) begin
               if (word_idx == LAST_WORD) begin
                  state_nx = DONE;
               end else begin
                  state_nx    = REQ;
                  word_idx_nx = word_idx + 1'b1;
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are registered from the next state; done lands on the cycle
   // DONE is left, which is also the first cycle busy is low again.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         word_idx          <= '0;
         rdr__dom__enable  <= 1'b0;
         rdr__dom__address <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
      end else begin
         state             <= state_nx;
         word_idx          <= word_idx_nx;
         rdr__dom__enable  <= (state_nx == REQ);
         rdr__dom__address <= (state_nx == REQ) ? word_idx_nx : '0;
         busy              <= (state_nx != IDLE);
         done              <= (state == DONE);
      end
   end

   // Read data is valid the cycle after enable, i.e. during WAIT.
   digest_reader_word_serializer #(
      .SYMBOL_WIDTH (SYMBOL_WIDTH)
   ) u_word_serializer (
      .clk       (clk),
      .reset     (reset),
      .load      (state == WAIT),
      .load_data (dom__rdr__data),
      .last_word (word_idx == LAST_WORD),
      .ready     (out_ready),
      .data      (out_data),
      .valid     (out_valid),
      .last      (out_last),
      .word_done (word_done)
   );

endmodule

// File: tb/tb_digest_reader.sv
// Directed bench for digest_reader: memory model, byte scoreboard, handshake
// and timing checks around readout, backpressure, ignored restart and reset.
module tb_digest_reader;
   import digest_reader_pkg::*;

   localparam int OUTPUT_LENGTH = 8;
   localparam int AW = 3;
   localparam logic [31:0] ABC [8] = '{
      32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
   };

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          finish = 1'b0;
   logic [AW-1:0] address;
   logic          enable;
   logic          write;
   logic [31:0]   mem_rdata;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic          busy;
   logic          done;

   logic [31:0] mem [OUTPUT_LENGTH];
   logic [8:0]  exp_q [$];

   int n_checks = 0;
   int n_fail = 0;
   int done_count = 0;
   int total_bytes = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (enable) mem_rdata <= mem[address];
   end

   digest_reader #(
      .OUTPUT_LENGTH (OUTPUT_LENGTH),
      .SYMBOL_WIDTH  (8)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .dut__xxx__finish  (finish),
      .rdr__dom__address (address),
      .rdr__dom__enable  (enable),
      .rdr__dom__write   (write),
      .dom__rdr__data    (mem_rdata),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_last          (out_last),
      .busy              (busy),
      .done              (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_address"}, 32'(address), 32'd0);
      check({tag, "_enable"}, 32'(enable), 32'd0);
      check({tag, "_write"}, 32'(write), 32'd0);
      check({tag, "_out_data"}, 32'(out_data), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_out_last"}, 32'(out_last), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // Runs on every falling edge: scoreboard pops, stall stability, addressing.
   task automatic monitor();
      int          cyc = 0;
      int          rd_bytes = 0;
      int          next_word = 0;
      int          word_end_cyc = 0;
      int          last_acc_cyc = 0;
      logic        prev_valid = 1'b0;
      logic        prev_ready = 1'b0;
      logic [7:0]  prev_data = '0;
      logic        prev_last = 1'b0;
      logic [8:0]  e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            prev_valid = 1'b0;
            rd_bytes = 0;
            next_word = 0;
            continue;
         end
         check("write_low", 32'(write), 32'd0);
         if (prev_valid && !prev_ready) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
            check("stall_last", 32'(out_last), 32'(prev_last));
         end
         if (enable) begin
            check("req_address", 32'(address), 32'(next_word));
            if (next_word != 0) check("req_gap", 32'(cyc - word_end_cyc), 32'd1);
            next_word++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_byte", 32'({out_last, out_data}), 32'h1ff);
            end else begin
               e = exp_q.pop_front();
               check("byte", 32'({out_last, out_data}), 32'(e));
            end
            if (rd_bytes % 4 == 3) word_end_cyc = cyc;
            if (out_last) last_acc_cyc = cyc;
            rd_bytes++;
            total_bytes++;
         end
         if (done) begin
            done_count++;
            check("done_delay", 32'(cyc - last_acc_cyc), 32'd2);
            check("done_bytes", 32'(rd_bytes), 32'(DIGEST_BYTES));
            check("done_busy", 32'(busy), 32'd0);
            check("done_valid", 32'(out_valid), 32'd0);
            rd_bytes = 0;
            next_word = 0;
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data = out_data;
         prev_last = out_last;
      end
   endtask

   // Queues the expected stream from the memory image, pulses finish and
   // checks the REQ / WAIT / first-SEND cycles.
   task automatic start_readout();
      logic [31:0] w;
      for (int i = 0; i < OUTPUT_LENGTH; i++) begin
         w = mem[i];
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back({(i == OUTPUT_LENGTH - 1) && (b == 3), w[31:24]});
            w = w << 8;
         end
      end
      @(posedge clk); #1 finish = 1'b1;
      @(posedge clk); #1 finish = 1'b0;
      check("req_enable", 32'(enable), 32'd1);
      check("req_addr0", 32'(address), 32'd0);
      check("req_busy", 32'(busy), 32'd1);
      check("req_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("wait_enable", 32'(enable), 32'd0);
      check("wait_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("first_valid", 32'(out_valid), 32'd1);
      check("first_data", 32'(out_data), 32'(mem[0][31:24]));
   endtask

   // mode 0: ready high, 1: pattern 1,0,0 repeating, 2: random
   task automatic run_ready(input int mode, input int target);
      for (int k = 0; k < 600 && done_count < target; k++) begin
         @(posedge clk); #1;
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (k % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
      check("done_count", 32'(done_count), 32'(target));
   endtask

   task automatic wait_bytes(input int target);
      for (int k = 0; k < 200 && total_bytes < target; k++) @(posedge clk);
      check("byte_progress", 32'(total_bytes >= target), 32'd1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int base;
      for (int i = 0; i < OUTPUT_LENGTH; i++) mem[i] = ABC[i];
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      reset = 1'b1;
      repeat (2) @(posedge clk);

      // basic readout, ready held high
      out_ready = 1'b1;
      base = done_count;
      start_readout();
      run_ready(0, base + 1);
      repeat (3) @(posedge clk);
      #1 check_idle("basic");

      // backpressure 1,0,0,...
      base = done_count;
      start_readout();
      run_ready(1, base + 1);
      repeat (3) @(posedge clk);
      #1 check_idle("bp");

      // random contents, random backpressure
      for (int i = 0; i < OUTPUT_LENGTH; i++) mem[i] = $urandom;
      out_ready = 1'b1;
      base = done_count;
      start_readout();
      run_ready(2, base + 1);
      repeat (3) @(posedge clk);
      #1 check_idle("rand");
      for (int i = 0; i < OUTPUT_LENGTH; i++) mem[i] = ABC[i];

      // second finish during word 2 is ignored
      out_ready = 1'b1;
      base = done_count;
      start_readout();
      wait_bytes(total_bytes + 9 - 1);
      @(posedge clk); #1 finish = 1'b1;
      @(posedge clk); #1 finish = 1'b0;
      run_ready(0, base + 1);
      repeat (20) @(posedge clk);
      #1 check("single_done", 32'(done_count), 32'(base + 1));
      check_idle("restart");

      // asynchronous reset during word 5, then a clean restart
      base = total_bytes;
      start_readout();
      wait_bytes(base + 21);
      #3 reset = 1'b0;
      #1 check_all_zero("midreset");
      exp_q.delete();
      @(posedge clk); #1 reset = 1'b1;
      base = done_count;
      repeat (2) @(posedge clk);
      #1 check("no_partial_done", 32'(done_count), 32'(base));
      start_readout();
      run_ready(0, base + 1);
      repeat (3) @(posedge clk);
      #1 check_idle("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/digest_reader.md
Name: digest_reader

Overview:
- Reads the finished digest words out of the output data memory after the hash core asserts finish.
- Serializes the digest into a byte stream with a valid/ready handshake for host or UART-side consumers.
- Sits beside the SHA-256 core on the shared output data memory, on the read port opposite the core's write port.

Parameters:
- OUTPUT_LENGTH, 8, number of 32-bit digest words in the output data memory.
- SYMBOL_WIDTH, 8, width of one output stream symbol; fixed at 8, 32/SYMBOL_WIDTH = 4 symbols per word.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- dut__xxx__finish  input  1  finish pulse from the hash core; starts a readout.
- rdr__dom__address  output  $clog2(OUTPUT_LENGTH)  output data memory word address.
- rdr__dom__enable  output  1  memory read enable.
- rdr__dom__write  output  1  memory write strobe; tied 0.
- dom__rdr__data  input  32  memory read data, valid the cycle after enable.
- out_data  output  SYMBOL_WIDTH  current digest byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the byte when out_valid && out_ready.
- out_last  output  1  high with the final byte (byte index 4*OUTPUT_LENGTH-1).
- busy  output  1  high from the cycle after start until DONE is exited.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (reset=0, async): state IDLE, word index 0, byte count 0.
  - All outputs 0: address, enable, write, out_data, out_valid, out_last, busy, done.
- All outputs are registered.
- States: IDLE, REQ, WAIT, SEND, DONE.
- IDLE
  - On dut__xxx__finish=1 at an edge -> REQ, word index 0, busy=1.
  - Otherwise stay in IDLE.
- REQ
  - Drive enable=1 and address=word index for exactly one cycle.
  - Then -> WAIT.
- WAIT
  - enable=0.
  - dom__rdr__data is captured into a 32-bit shift register at the end of WAIT.
  - Then -> SEND, with out_valid=1 and out_data=word[31:24].
- SEND
  - On an accepted beat, shift left by 8 and increment the byte-in-word counter (0..3).
  - Bytes go out MSB first: [31:24], [23:16], [15:8], [7:0].
  - After the 4th accepted byte:
    - if word index == OUTPUT_LENGTH-1 -> DONE;
    - else increment word index -> REQ.
  - out_valid drops for the REQ and WAIT cycles between words.
- DONE
  - done=1 and busy=0 for one cycle, out_valid=0, then -> IDLE.
- Latency: finish edge to first out_valid = 3 cycles (REQ, WAIT, SEND).
- Throughput with out_ready held high: 4 bytes per 6 cycles.
- Handshake rules:
  - Once out_valid=1, out_data and out_last hold stable until accepted.
  - out_valid never drops without acceptance.
  - out_ready while out_valid=0 has no effect.
- out_last=1 only while the final byte is presented.
- dut__xxx__finish in any state other than IDLE is ignored; no restart and no queuing.
- finish in the same cycle as the DONE->IDLE transition is ignored. A new readout requires finish while in IDLE.
- Reset asserted mid-readout aborts immediately to the reset values. No partial done pulse.
- Word index and address wrap is impossible; the last index is OUTPUT_LENGTH-1 and the block terminates there.
- rdr__dom__write is constant 0 in all states.

Decomposition:
- Shared package:
  - state enum (IDLE, REQ, WAIT, SEND, DONE);
  - BYTES_PER_WORD = 4;
  - DIGEST_BYTES = 4*OUTPUT_LENGTH.
- One natural sub-module, word_serializer: a 32-bit load/shift register with byte counter, valid/ready logic and a last-byte flag.
- digest_reader keeps the FSM and memory addressing.

Test Plan:
- Basic readout:
  - Stimulus: preload memory with the SHA-256("abc") digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; pulse finish; out_ready=1.
  - Response: 32 bytes 0xba, 0x78, ... 0x15, 0xad in order.
  - out_last only on 0xad; done pulses once, 2 cycles after the last accept.
- Backpressure:
  - Stimulus: same memory, out_ready toggled with pattern 1,0,0,1,...
  - Response: identical byte sequence; out_data and out_valid stable during stalls; no bytes dropped or duplicated.
- Timing:
  - Response: finish at cycle 0 gives enable=1 with address=0 at cycle 1 and out_valid=1 with out_data=0xba at cycle 3.
  - Address 1 appears one cycle after the 4th accept.
- Start while busy:
  - Stimulus: a second finish pulse during SEND of word 2.
  - Response: ignored; exactly 32 bytes and a single done.
- Reset mid-operation:
  - Stimulus: reset=0 asynchronously during word 5.
  - Response: all outputs 0 immediately; a subsequent finish restarts from address 0 with byte 0xba.
- Write strobe:
  - Response: rdr__dom__write=0 across all of the above.
